// File: rtl/neuron_lut_loader.sv
// Runtime-loadable LogicNets neuron truth table: a valid/ready config stream fills
// the table word by word, then registered one-cycle lookups are served from it.
module neuron_lut_loader #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2,
  parameter int WORD_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_restart,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_last,
  input  logic                lk_valid,
  input  logic [IN_BITS-1:0]  lk_addr,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data,
  output logic                table_ready,
  output logic                cfg_err
);

  localparam int EPW     = WORD_W / OUT_BITS;
  localparam int NWORDS  = (2 ** IN_BITS) * OUT_BITS / WORD_W;
  localparam int SEL_W   = $clog2(EPW);
  localparam int WADDR_W = IN_BITS - SEL_W;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_READY = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [WADDR_W-1:0]  cnt_q, cnt_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                table_ready_q, table_ready_d;
  logic                cfg_err_q, cfg_err_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_BITS-1:0] out_data_q;
  logic                wr_en;
  logic                handshake;
  logic                cnt_at_end;
  logic                lk_accept;

  logic [WORD_W-1:0]   mem_q [NWORDS];
  logic [WORD_W-1:0]   rd_word;
  logic [OUT_BITS-1:0] rd_entry [EPW];

  assign handshake  = cfg_valid & cfg_ready_q;
  assign cnt_at_end = (cnt_q == WADDR_W'(NWORDS - 1));
  assign lk_accept  = lk_valid & table_ready_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cfg_ready_d   = cfg_ready_q;
    table_ready_d = table_ready_q;
    cfg_err_d     = cfg_err_q;
    wr_en         = 1'b0;
    if (cfg_restart) begin
      // Restart wins over a same-cycle handshake: the word is dropped.
      state_d       = ST_LOAD;
      cnt_d         = '0;
      cfg_ready_d   = 1'b1;
      table_ready_d = 1'b0;
      cfg_err_d     = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          cfg_ready_d = 1'b1;
          if (handshake) begin
            wr_en = 1'b1;
            if (cfg_last != cnt_at_end) begin
              state_d     = ST_ERROR;
              cfg_ready_d = 1'b0;
              cfg_err_d   = 1'b1;
            end else if (cfg_last) begin
              state_d       = ST_READY;
              cfg_ready_d   = 1'b0;
              table_ready_d = 1'b1;
            end else begin
              cnt_d = cnt_q + WADDR_W'(1);
            end
          end
        end
        ST_READY: begin
          cfg_ready_d   = 1'b0;
          table_ready_d = 1'b1;
        end
        default: begin
          state_d       = ST_ERROR;
          cfg_ready_d   = 1'b0;
          table_ready_d = 1'b0;
          cfg_err_d     = 1'b1;
        end
      endcase
    end
    out_valid_d = lk_accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_LOAD;
      cnt_q         <= '0;
      cfg_ready_q   <= 1'b0;
      table_ready_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cfg_ready_q   <= cfg_ready_d;
      table_ready_q <= table_ready_d;
      cfg_err_q     <= cfg_err_d;
      out_valid_q   <= out_valid_d;
    end
  end

  // Table storage is deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[cnt_q] <= cfg_data;
    end
  end

  assign rd_word = mem_q[lk_addr[IN_BITS-1:SEL_W]];

  for (genvar gi = 0; gi < EPW; gi++) begin : g_entry
    assign rd_entry[gi] = rd_word[gi*OUT_BITS +: OUT_BITS];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q <= '0;
    end else if (lk_accept) begin
      out_data_q <= rd_entry[lk_addr[SEL_W-1:0]];
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign table_ready = table_ready_q;
  assign cfg_err     = cfg_err_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;

endmodule
